// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : snn_pkg
//  Description : Shared definitions for the SNN core datapath: global phase
//                codes, default array geometry, weight/potential widths and
//                the membrane-potential saturation helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package snn_pkg;

    // Global phase codes driven by the SNN controller.
    typedef enum logic [2:0] {
        PH_IDLE     = 3'd0,
        PH_SET      = 3'd1,
        PH_SYN_ACCU = 3'd2,
        PH_DECAY    = 3'd3,
        PH_PDE      = 3'd4,
        PH_FINISH   = 3'd5,
        PH_DONE     = 3'd6
    } phase_e;

    localparam int N_NUM   = 32;  // presynaptic neurons (weight rows)
    localparam int N_SZ    = 5;   // log2(N_NUM)
    localparam int G_NUM   = 4;   // output neurons
    localparam int G_SZ    = 2;   // log2(G_NUM)
    localparam int W_W     = 8;   // signed weight width
    localparam int V_W     = 16;  // signed membrane-potential width
    localparam int LEAK_SH = 3;   // leak shift amount

    // Clamp a signed value to the range of a vw-bit two's-complement number.
    // The caller truncates the result back to vw bits.
    function automatic logic signed [31:0] saturate(input logic signed [31:0] x,
                                                   input int                 vw);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (vw - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (vw - 1));
        if (x > hi) begin
            saturate = hi;
        end else if (x < lo) begin
            saturate = lo;
        end else begin
            saturate = x;
        end
    endfunction

endpackage : snn_pkg
`default_nettype wire

// File: rtl/syn_accu_lane.sv
`default_nettype none
// ============================================================================
//  Module      : syn_accu_lane
//  Description : One output neuron: membrane-potential register with the
//                two-weight add/saturate, leak and threshold/fire/reset.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk        in   clock
//    rst        in   synchronous active-low reset
//    acc_apply  in   apply the accumulation operands this cycle
//    s0, s1     in   spike bits selecting w0 / w1
//    w0, w1     in   signed weights of the two rows for this neuron
//    decay_en   in   apply leak this cycle
//    pde_en     in   apply fire/reset this cycle
//    clr        in   clear potential (loses against acc_apply)
//    vth        in   signed fire threshold
//    v          out  current membrane potential
//    fire       out  V >= vth (combinational)
// ============================================================================
module syn_accu_lane #(
    parameter int W_W     = 8,
    parameter int V_W     = 16,
    parameter int LEAK_SH = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           acc_apply,
    input  logic           s0,
    input  logic           s1,
    input  logic [W_W-1:0] w0,
    input  logic [W_W-1:0] w1,
    input  logic           decay_en,
    input  logic           pde_en,
    input  logic           clr,
    input  logic [V_W-1:0] vth,
    output logic [V_W-1:0] v,
    output logic           fire
);
    import snn_pkg::*;

    // Rounding bias that makes the leak term truncate toward zero, so a
    // small negative potential (e.g. -1) is not pulled to zero by the floor
    // behaviour of an arithmetic shift.
    localparam logic [V_W-1:0] C_RND = V_W'((1 << LEAK_SH) - 1);

    logic        [V_W-1:0] r_v;
    logic        [V_W+1:0] w_vx;
    logic        [V_W+1:0] w_w0x;
    logic        [V_W+1:0] w_w1x;
    logic signed [V_W+1:0] w_sum;
    logic        [V_W-1:0] w_sat;
    logic signed [V_W-1:0] w_biased;
    logic signed [V_W-1:0] w_leak;
    logic        [V_W-1:0] w_decayed;

    // Two extra bits of headroom hold V + two full-scale weights exactly.
    assign w_vx  = {{2{r_v[V_W-1]}}, r_v};
    assign w_w0x = {{(V_W+2-W_W){w0[W_W-1]}}, w0};
    assign w_w1x = {{(V_W+2-W_W){w1[W_W-1]}}, w1};
    assign w_sum = w_vx + (s0 ? w_w0x : '0) + (s1 ? w_w1x : '0);
    assign w_sat = V_W'(saturate(32'(w_sum), V_W));

    // Adding the bias to a negative value cannot overflow.
    assign w_biased  = r_v + (r_v[V_W-1] ? C_RND : '0);
    assign w_leak    = w_biased >>> LEAK_SH;
    assign w_decayed = r_v - w_leak;

    assign fire = ($signed(r_v) >= $signed(vth));
    assign v    = r_v;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_v <= '0;
        end else if (acc_apply) begin
            r_v <= w_sat;
        end else if (clr) begin
            r_v <= '0;
        end else if (decay_en) begin
            r_v <= w_decayed;
        end else if (pde_en && fire) begin
            r_v <= '0;
        end
    end

endmodule : syn_accu_lane
`default_nettype wire

// File: rtl/syn_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : syn_accumulator
//  Description : Synaptic accumulator downstream of the spike decoder. Each
//                accepted spike pair reads two weight rows and adds the
//                weights of the spiking inputs into G_NUM membrane
//                potentials; DECAY applies leak and PDE applies
//                threshold/fire/reset on phase entry.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk            in   clock
//    rst            in   synchronous active-low reset
//    state          in   global phase code
//    spike          in   spike pair (bit0 -> row rf_addr, bit1 -> rf_addr+1)
//    rf_addr        in   base row of the pair
//    acc_en         in   pair valid this cycle
//    accu_fin       in   last pair of the timestep (same cycle as the pair)
//    v_clr          in   clear all potentials
//    wt_we          in   weight write strobe (ignored in SYN_ACCU)
//    wt_addr        in   weight row to write
//    wt_data        in   row data, slice g = weight to neuron g
//    vth            in   signed fire threshold
//    v_out          out  potentials, slice g = neuron g
//    spike_out      out  fire vector of the last PDE
//    spike_out_vld  out  one-cycle pulse when spike_out updates
//    accu_done      out  one-cycle pulse when accumulation has drained
// ============================================================================
module syn_accumulator #(
    parameter int N_NUM   = snn_pkg::N_NUM,
    parameter int N_SZ    = snn_pkg::N_SZ,
    parameter int G_NUM   = snn_pkg::G_NUM,
    parameter int W_W     = snn_pkg::W_W,
    parameter int V_W     = snn_pkg::V_W,
    parameter int LEAK_SH = snn_pkg::LEAK_SH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           state,
    input  logic [1:0]           spike,
    input  logic [N_SZ-1:0]      rf_addr,
    input  logic                 acc_en,
    input  logic                 accu_fin,
    input  logic                 v_clr,
    input  logic                 wt_we,
    input  logic [N_SZ-1:0]      wt_addr,
    input  logic [G_NUM*W_W-1:0] wt_data,
    input  logic [V_W-1:0]       vth,
    output logic [G_NUM*V_W-1:0] v_out,
    output logic [G_NUM-1:0]     spike_out,
    output logic                 spike_out_vld,
    output logic                 accu_done
);
    import snn_pkg::*;

    localparam int ROW_W = G_NUM * W_W;

    logic [2:0]       r_state_d;
    logic [ROW_W-1:0] r_wt [N_NUM];

    // Stage-1 pipeline register (pair captured on acc_en)
    logic             r_p_vld;
    logic             r_p_fin;
    logic [1:0]       r_p_spike;
    logic [ROW_W-1:0] r_p_w0;
    logic [ROW_W-1:0] r_p_w1;

    logic [G_NUM-1:0] r_spike_out;
    logic             r_spike_out_vld;
    logic             r_accu_done;

    logic             w_entry;
    logic             w_in_accu;
    logic             w_take;
    logic             w_apply;
    logic             w_decay_en;
    logic             w_pde_en;
    logic [N_SZ-1:0]  w_addr_nxt;
    logic [G_NUM-1:0] w_fire;

    assign w_entry    = (state != r_state_d);
    assign w_in_accu  = (state == PH_SYN_ACCU);
    assign w_take     = w_in_accu && acc_en;
    // A captured pair only lands if the phase is still SYN_ACCU one cycle
    // later; leaving the phase discards anything in flight.
    assign w_apply    = r_p_vld && w_in_accu;
    assign w_decay_en = (state == PH_DECAY) && w_entry;
    assign w_pde_en   = (state == PH_PDE) && w_entry;
    assign w_addr_nxt = (rf_addr == N_SZ'(N_NUM - 1)) ? '0 : rf_addr + N_SZ'(1);

    // Phase tracking
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_d <= PH_IDLE;
        end else begin
            r_state_d <= state;
        end
    end

    // Weight RAM; writes are locked out while accumulation reads it so no
    // read/write bypass is needed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_NUM; i++) begin
                r_wt[i] <= '0;
            end
        end else if (wt_we && !w_in_accu) begin
            r_wt[wt_addr] <= wt_data;
        end
    end

    // Stage 1: capture the pair and both weight rows
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_p_vld   <= 1'b0;
            r_p_fin   <= 1'b0;
            r_p_spike <= '0;
            r_p_w0    <= '0;
            r_p_w1    <= '0;
        end else begin
            r_p_vld <= w_take;
            r_p_fin <= w_take && accu_fin;
            if (w_take) begin
                r_p_spike <= spike;
                r_p_w0    <= r_wt[rf_addr];
                r_p_w1    <= r_wt[w_addr_nxt];
            end
        end
    end

    // Status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_spike_out     <= '0;
            r_spike_out_vld <= 1'b0;
            r_accu_done     <= 1'b0;
        end else begin
            r_spike_out_vld <= w_pde_en;
            r_accu_done     <= w_apply && r_p_fin;
            if (w_pde_en) begin
                r_spike_out <= w_fire;
            end
        end
    end

    assign spike_out     = r_spike_out;
    assign spike_out_vld = r_spike_out_vld;
    assign accu_done     = r_accu_done;

    // Stage 2: per-neuron potential lanes
    for (genvar g = 0; g < G_NUM; g++) begin : g_lane
        syn_accu_lane #(
            .W_W     (W_W),
            .V_W     (V_W),
            .LEAK_SH (LEAK_SH)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .acc_apply (w_apply),
            .s0        (r_p_spike[0]),
            .s1        (r_p_spike[1]),
            .w0        (r_p_w0[g*W_W +: W_W]),
            .w1        (r_p_w1[g*W_W +: W_W]),
            .decay_en  (w_decay_en),
            .pde_en    (w_pde_en),
            .clr       (v_clr),
            .vth       (vth),
            .v         (v_out[g*V_W +: V_W]),
            .fire      (w_fire[g])
        );
    end

endmodule : syn_accumulator
`default_nettype wire
